// File: rtl/mem_pkg.sv
// Shared definitions for the load/store path: access-size encodings,
// the load/store FSM states and the natural-alignment rule.
package mem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when an access of the given size is not naturally aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] low);
    case (size)
      SIZE_H:  misaligned = low[0];
      SIZE_W:  misaligned = |low[1:0];
      SIZE_D:  misaligned = |low[2:0];
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lane_extend.sv
// Load-data lane select plus sign/zero extension.
// Ports:
//   data       full-width bus read data
//   offset     byte offset of the access within the bus word (aligned)
//   size       access size (mem_pkg size encoding)
//   zero_ext   1 = zero-extend, 0 = sign-extend
//   result     right-justified, extended value
module lane_extend
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]             data,
  input  logic [$clog2(DATA_W/8)-1:0]   offset,
  input  logic [1:0]                    size,
  input  logic                          zero_ext,
  output logic [DATA_W-1:0]             result
);

  logic [DATA_W-1:0] shifted;

  // Accesses are aligned, so the byte offset alone right-justifies the lane.
  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (size)
      SIZE_B:  result = zero_ext ? DATA_W'(shifted[7:0])  : DATA_W'(signed'(shifted[7:0]));
      SIZE_H:  result = zero_ext ? DATA_W'(shifted[15:0]) : DATA_W'(signed'(shifted[15:0]));
      SIZE_W:  result = zero_ext ? DATA_W'(shifted[31:0]) : DATA_W'(signed'(shifted[31:0]));
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: turns one decoded memory op into a handshaked
// data-bus transaction, with alignment checks, pipeline stall and load
// data extension.
// Ports:
//   clk, reset (async, active-high)
//   req_valid/req_we/req_size/req_unsigned/req_addr/req_wdata : M-stage op
//   stall, rsp_valid, rsp_rdata                                : pipeline side
//   exc_adel, exc_ades, exc_bus                                : exception pulses
//   bus_req/bus_we/bus_addr/bus_be/bus_wdata, bus_ack/bus_rdata: data bus
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                stall,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                exc_adel,
  output logic                exc_ades,
  output logic                exc_bus,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_be,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned K  = $clog2(NB);
  localparam int unsigned TW = $clog2(TIMEOUT + 1) + 1;

  state_e            state;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [K-1:0]      off_q;
  logic [ADDR_W-1:0] addr_q;
  logic [NB-1:0]     be_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [TW-1:0]     timer;
  logic              exc_bus_q;

  logic              legal;
  logic              bad;
  logic              idle_req;
  logic              accept;
  logic [NB-1:0]     be_n;
  logic [DATA_W-1:0] wdata_n;
  logic [DATA_W-1:0] ext;

  always_comb begin
    legal    = (req_size != SIZE_D) || (DATA_W == 64);
    bad      = !legal || misaligned(req_size, req_addr[2:0]);
    idle_req = (state == ST_IDLE) && req_valid && !reset;
    accept   = idle_req && !bad;

    // Aligned offset doubles as the shift for half/word masks.
    case (req_size)
      SIZE_B:  begin be_n = NB'(1)    << req_addr[K-1:0]; wdata_n = {NB{req_wdata[7:0]}};        end
      SIZE_H:  begin be_n = NB'(3)    << req_addr[K-1:0]; wdata_n = {(NB/2){req_wdata[15:0]}};   end
      SIZE_W:  begin be_n = NB'(4'hF) << req_addr[K-1:0]; wdata_n = {(NB/4){req_wdata[31:0]}};   end
      default: begin be_n = '1;                            wdata_n = req_wdata;                   end
    endcase
    if (!req_we) be_n = '1;
  end

  lane_extend #(.DATA_W(DATA_W)) u_lane_extend (
    .data     (bus_rdata),
    .offset   (off_q),
    .size     (size_q),
    .zero_ext (uns_q),
    .result   (ext)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      we_q      <= 1'b0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      timer     <= '0;
      exc_bus_q <= 1'b0;
    end else begin
      exc_bus_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            off_q   <= req_addr[K-1:0];
            addr_q  <= {req_addr[ADDR_W-1:K], {K{1'b0}}};
            be_q    <= be_n;
            wdata_q <= req_we ? wdata_n : '0;
            timer   <= '0;
            state   <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (bus_ack) begin
            rdata_q <= we_q ? '0 : ext;
            state   <= ST_DONE;
          end else if (TIMEOUT != 0 && timer == TW'(TIMEOUT - 1)) begin
            exc_bus_q <= 1'b1;
            state     <= ST_IDLE;
          end else if (TIMEOUT != 0) begin
            timer <= timer + TW'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign stall     = accept || (state == ST_BUS);
  assign rsp_valid = (state == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign exc_adel  = idle_req && bad && !req_we;
  assign exc_ades  = idle_req && bad && req_we;
  assign exc_bus   = exc_bus_q;
  assign bus_req   = (state == ST_BUS);
  assign bus_we    = bus_req && we_q;
  assign bus_addr  = bus_req ? addr_q  : '0;
  assign bus_be    = bus_req ? be_q    : '0;
  assign bus_wdata = bus_req ? wdata_q : '0;

endmodule
